// File: rtl/moonbase_bus_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// moonbase_bus_pkg : io-bus bit positions and nibble helpers   rev 1.0
// ---------------------------------------------------------------------------
package moonbase_bus_pkg;

  localparam int STROBE  = 7;
  localparam int SPACE   = 6;
  localparam int RAM_WN  = 5;
  localparam int DEV_WN  = 4;
  localparam int DATA_HI = 3;
  localparam int DATA_LO = 0;

  localparam logic SPACE_CODE = 1'b1;
  localparam logic SPACE_DATA = 1'b0;

  typedef enum logic {
    NIB_HI = 1'b0,
    NIB_LO = 1'b1
  } nib_e;

  function automatic logic [3:0] nibble_of(input logic [7:0] b, input nib_e n);
    return (n == NIB_HI) ? b[7:4] : b[3:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/moonbase_bus_responder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// moonbase_bus_responder_if : CPU multiplexed io bus   rev 1.0
// ---------------------------------------------------------------------------
interface moonbase_bus_responder_if;

  logic [7:0] bus_out;
  logic [3:0] ram_data;
  logic [1:0] dev_data;

  modport master (output bus_out, input  ram_data, input  dev_data);
  modport slave  (input  bus_out, output ram_data, output dev_data);

endinterface
`default_nettype wire

// File: rtl/moonbase_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// moonbase_sync : STAGES-deep per-bit synchroniser   rev 1.0
// ---------------------------------------------------------------------------
module moonbase_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/moonbase_bus_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// moonbase_bus_responder : address latch, 256x8 SRAM and device responder   rev 1.0
// ---------------------------------------------------------------------------
module moonbase_bus_responder
  import moonbase_bus_pkg::*;
#(
  parameter int N_DEV       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  moonbase_bus_responder_if.slave bus,
  input  logic [7:0]           gpio_in,
  output logic [8*N_DEV-1:0]   dev_out,
  output logic                 dev_wr_stb,
  output logic [2:0]           dev_wr_addr,
  input  logic                 prog_we,
  input  logic [7:0]           prog_addr,
  input  logic [7:0]           prog_data
);

  logic [7:0] r_mem [256];
  logic [6:0] r_addr;
  nib_e       r_nib;
  logic [3:0] r_hold;

  logic [7:0] w_idx;
  logic [3:0] w_wdata;
  logic       w_strobe;
  logic       w_ram_we;
  logic       w_dev_we;
  logic       w_dev_commit;
  logic       w_prog_hit;
  logic [7:0] w_rd_byte;
  logic [7:0] w_gpio_s;

  assign w_strobe     = bus.bus_out[STROBE];
  assign w_idx        = {bus.bus_out[SPACE], r_addr};
  assign w_wdata      = bus.bus_out[DATA_HI:DATA_LO];
  assign w_ram_we     = !w_strobe && !bus.bus_out[RAM_WN];
  assign w_dev_we     = !w_strobe && !bus.bus_out[DEV_WN];
  assign w_dev_commit = w_dev_we && (r_nib == NIB_LO) && (int'(r_addr[2:0]) < N_DEV);
  assign w_prog_hit   = prog_we && (prog_addr == w_idx);

  // The CPU samples the read nibble in the same cycle, so no register here.
  assign w_rd_byte    = r_mem[w_idx];
  assign bus.ram_data = nibble_of(w_rd_byte, r_nib);
  assign bus.dev_data = w_gpio_s[{r_addr[1:0], 1'b0} +: 2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr      <= '0;
      r_nib       <= NIB_HI;
      r_hold      <= '0;
      dev_wr_stb  <= 1'b0;
      dev_wr_addr <= '0;
    end else begin
      dev_wr_stb <= 1'b0;
      if (w_strobe) begin
        r_addr <= bus.bus_out[6:0];
        r_nib  <= NIB_HI;
      end else begin
        r_nib <= (r_nib == NIB_HI) ? NIB_LO : NIB_HI;
        if (w_dev_we && (r_nib == NIB_HI)) r_hold <= w_wdata;
        if (w_dev_commit) begin
          dev_wr_stb  <= 1'b1;
          dev_wr_addr <= r_addr[2:0];
        end
      end
    end
  end

  // Host byte writes override a bus nibble aimed at the same byte.
  always_ff @(posedge clk) begin
    if (reset_n && w_ram_we && !w_prog_hit) begin
      if (r_nib == NIB_HI) r_mem[w_idx][7:4] <= w_wdata;
      else                 r_mem[w_idx][3:0] <= w_wdata;
    end
    if (prog_we) r_mem[prog_addr] <= prog_data;
  end

  for (genvar k = 0; k < N_DEV; k++) begin : g_dev
    logic [7:0] r_reg;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                  r_reg <= '0;
      else if (w_dev_commit && (r_addr[2:0] == 3'(k))) r_reg <= {r_hold, w_wdata};
    end
    assign dev_out[8*k +: 8] = r_reg;
  end

  moonbase_sync #(
    .WIDTH  (8),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (gpio_in),
    .o_q     (w_gpio_s)
  );

endmodule
`default_nettype wire

// File: tb/tb_moonbase_bus_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_moonbase_bus_responder : scoreboard bench with a cycle-level reference model   rev 1.0
// ---------------------------------------------------------------------------
module tb_moonbase_bus_responder;

  localparam int N_DEV  = 8;
  localparam int SYNC   = 2;
  localparam int K_RAM  = 0;
  localparam int K_DEV  = 1;
  localparam int K_DOUT = 2;

  typedef struct {
    int          cyc;
    int          kind;
    logic [63:0] exp;
    string       name;
  } item_t;

  typedef struct {
    int          cyc;
    logic [2:0]  addr;
    logic [63:0] dout;
  } stb_t;

  item_t sbq[$];
  stb_t  stbq[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  gpio_in;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [7:0]  prog_data;
  wire  [63:0] dev_out;
  wire         dev_wr_stb;
  wire  [2:0]  dev_wr_addr;

  moonbase_bus_responder_if bus ();

  moonbase_bus_responder #(
    .N_DEV       (N_DEV),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus.slave),
    .gpio_in     (gpio_in),
    .dev_out     (dev_out),
    .dev_wr_stb  (dev_wr_stb),
    .dev_wr_addr (dev_wr_addr),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [7:0] m_mem [256];
  logic [6:0] m_addr;
  logic       m_nib;
  logic [3:0] m_hold;
  logic [7:0] m_dev [N_DEV];
  logic [7:0] m_gp  [256];
  logic [7:0] g_gpio;
  int         rel_cyc = 0;
  logic       prev_rn = 1'b0;

  function automatic logic [7:0] preload(input int i);
    return 8'((i * 29 + 7) & 255);
  endfunction

  function automatic logic [63:0] devvec();
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < N_DEV; k++) v[8*k +: 8] = m_dev[k];
    return v;
  endfunction

  task automatic expect_now(input int kind, input logic [63:0] e, input string nm);
    sbq.push_back('{cyc, kind, e, nm});
  endtask

  task automatic compare(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  // Drive one bus cycle and advance the model across the following clock edge.
  task automatic step(input logic rn, input logic [7:0] bo, input logic pw,
                      input logic [7:0] pa, input logic [7:0] pd);
    int         c;
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] idx;
    @(posedge clk);
    #1;
    reset_n     = rn;
    bus.bus_out = bo;
    prog_we     = pw;
    prog_addr   = pa;
    prog_data   = pd;
    gpio_in     = g_gpio;
    c = cyc;
    if (!rn) begin
      m_addr = '0;
      m_nib  = 1'b0;
      m_hold = '0;
      for (int k = 0; k < N_DEV; k++) m_dev[k] = '0;
    end
    if (rn && !prev_rn) rel_cyc = c;
    prev_rn = rn;
    m_gp[c % 256] = g_gpio;

    idx = {bo[6], m_addr};
    b   = m_mem[idx];
    expect_now(K_RAM, 64'(m_nib ? b[3:0] : b[7:4]), "ram_data");
    if (rn && (c - rel_cyc >= SYNC)) begin
      g = m_gp[(c - SYNC) % 256] >> (2 * m_addr[1:0]);
      expect_now(K_DEV, 64'(g[1:0]), "dev_data");
    end
    expect_now(K_DOUT, devvec(), "dev_out");

    if (rn) begin
      if (bo[7]) begin
        m_addr = bo[6:0];
        m_nib  = 1'b0;
      end else begin
        if (!bo[5]) begin
          if (m_nib) m_mem[idx][3:0] = bo[3:0];
          else       m_mem[idx][7:4] = bo[3:0];
        end
        if (!bo[4]) begin
          if (!m_nib) m_hold = bo[3:0];
          else if (int'(m_addr[2:0]) < N_DEV) begin
            m_dev[m_addr[2:0]] = {m_hold, bo[3:0]};
            stbq.push_back('{c + 1, m_addr[2:0], devvec()});
          end
        end
        m_nib = ~m_nib;
      end
    end
    if (pw) m_mem[pa] = pd;
  endtask

  task automatic bus_cyc(input logic [7:0] bo);
    step(1'b1, bo, 1'b0, 8'h00, 8'h00);
  endtask

  // Monitor: pops expectations for the current cycle and checks device pulses.
  always @(negedge clk) begin : mon
    item_t       it;
    stb_t        s;
    logic [63:0] act;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      it = sbq.pop_front();
      case (it.kind)
        K_RAM:   act = 64'(bus.ram_data);
        K_DEV:   act = 64'(bus.dev_data);
        default: act = dev_out;
      endcase
      compare(it.name, act, it.exp);
    end
    if (dev_wr_stb !== 1'b0) begin
      if (stbq.size() == 0 || stbq[0].cyc != cyc) begin
        checks++;
        errors++;
        $display("FAIL dev_wr_stb_unexpected cyc=%0d actual=%b required=0", cyc, dev_wr_stb);
      end else begin
        s = stbq.pop_front();
        compare("dev_wr_addr", 64'(dev_wr_addr), 64'(s.addr));
        compare("dev_out_at_stb", dev_out, s.dout);
      end
    end else if (stbq.size() > 0 && stbq[0].cyc <= cyc) begin
      s = stbq.pop_front();
      checks++;
      errors++;
      $display("FAIL dev_wr_stb_missing cyc=%0d actual=0 required=1", cyc);
    end
  end

  initial begin
    logic [7:0] bo;
    logic       pw;
    logic [7:0] pa;
    reset_n     = 1'b0;
    bus.bus_out = 8'h80;
    prog_we     = 1'b0;
    prog_addr   = '0;
    prog_data   = '0;
    g_gpio      = 8'h00;
    gpio_in     = 8'h00;
    for (int i = 0; i < 256; i++) m_gp[i] = '0;

    step(1'b0, 8'h80, 1'b0, 8'h00, 8'h00);
    step(1'b0, 8'h80, 1'b0, 8'h00, 8'h00);
    expect_now(K_DOUT, 64'h0, "reset_dev_out");
    for (int i = 0; i < 256; i++) step(1'b1, 8'h80, 1'b1, 8'(i), preload(i));

    // Code read, high nibble first
    step(1'b1, 8'h80, 1'b1, 8'h85, 8'h7A);
    bus_cyc(8'h85);
    bus_cyc(8'h70); expect_now(K_RAM, 64'h7, "code05_hi");
    bus_cyc(8'h70); expect_now(K_RAM, 64'hA, "code05_lo");

    // Data-space nibble writes, code space untouched
    bus_cyc(8'h90);
    bus_cyc(8'h13);
    bus_cyc(8'h1C);
    bus_cyc(8'h90);
    bus_cyc(8'h30); expect_now(K_RAM, 64'h3, "data10_hi");
    bus_cyc(8'h30); expect_now(K_RAM, 64'hC, "data10_lo");
    bus_cyc(8'h90);
    bus_cyc(8'h70); expect_now(K_RAM, 64'(preload(8'h90) >> 4), "code10_hi");
    bus_cyc(8'h70); expect_now(K_RAM, 64'(preload(8'h90) & 8'h0F), "code10_lo");

    // Device byte commit to register 2
    bus_cyc(8'h82);
    bus_cyc(8'h29);
    bus_cyc(8'h25);
    bus_cyc(8'h82); expect_now(K_DOUT, 64'h0000_0000_0095_0000, "dev2_commit");

    // gpio selection via addr_q[1:0]
    g_gpio = 8'hE4;
    bus_cyc(8'h82);
    bus_cyc(8'h82);
    bus_cyc(8'h82); expect_now(K_DEV, 64'h2, "gpio_addr2");
    bus_cyc(8'h83);
    bus_cyc(8'h83); expect_now(K_DEV, 64'h3, "gpio_addr3");

    // Reset after a device high nibble drops the hold value
    bus_cyc(8'h81);
    bus_cyc(8'h2F);
    step(1'b0, 8'h80, 1'b0, 8'h00, 8'h00);
    expect_now(K_DOUT, 64'h0, "mid_reset_dev_out");
    step(1'b0, 8'h80, 1'b0, 8'h00, 8'h00);
    bus_cyc(8'h81);
    bus_cyc(8'h30);
    bus_cyc(8'h24);
    bus_cyc(8'h81); expect_now(K_DOUT, 64'h0000_0000_0000_0400, "dev1_after_reset");

    // Host write wins a same-byte collision
    bus_cyc(8'hA0);
    step(1'b1, 8'h10, 1'b1, 8'h20, 8'hFF);
    bus_cyc(8'hA0);
    bus_cyc(8'h30); expect_now(K_RAM, 64'hF, "collide_hi");
    bus_cyc(8'h30); expect_now(K_RAM, 64'hF, "collide_lo");

    // Randomised traffic against the model
    for (int n = 0; n < 1500; n++) begin
      bo    = 8'($urandom);
      bo[7] = ($urandom_range(3) == 0);
      pw    = ($urandom_range(7) == 0);
      pa    = 8'($urandom);
      if ($urandom_range(1) == 1) pa = {bo[6], m_addr};
      if ($urandom_range(15) == 0) g_gpio = 8'($urandom);
      step(1'b1, bo, pw, pa, 8'($urandom));
    end

    for (int n = 0; n < 4; n++) bus_cyc({1'b1, m_addr});
    @(negedge clk);
    #1;
    checks++;
    if (stbq.size() != 0 || sbq.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d/%0d pending required=0/0", stbq.size(), sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/moonbase_bus_responder.md
Name: moonbase_bus_responder

Overview:
- Bus-side counterpart of the 8-bit nibble CPU: the address latch, code/data SRAM and device responder that sit on the CPU's multiplexed io bus.
- Latches the 7-bit address on strobe cycles and serves read nibbles back combinationally, high nibble first.
- Captures RAM and device writes, and presents 2-bit device input data.
- Replaces discrete latch/SRAM/glue logic in on-chip system builds and in the CPU test bench.

Parameters:
- N_DEV, 8, number of 8-bit device output registers (power of 2, at most 8).
- SYNC_STAGES, 2, synchroniser depth on gpio_in.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- bus_out  in  8  CPU io_out.
  - [7] strobe; when 1, [6:0] is the address.
  - When strobe is 0: [6] code space (1) or data space (0); [5] ram write_n; [4] device write_n; [3:0] write nibble.
- ram_data  out  4  drives CPU io_in[5:2].
- dev_data  out  2  drives CPU io_in[7:6].
- gpio_in  in  8  asynchronous external inputs.
- dev_out  out  8*N_DEV  device registers, flattened; reg k occupies [8k+7:8k].
- dev_wr_stb  out  1  one-cycle pulse when a device byte commits.
- dev_wr_addr  out  3  register index of the commit.
- prog_we  in  1  host/bench byte write strobe.
- prog_addr  in  8  host byte address; [7] selects code (1) or data (0).
- prog_data  in  8  host write byte.

Behaviour:
- Storage is 256 bytes, indexed {space, addr}. Memory has no reset; contents are undefined until written.
- Reset values: addr_q=0, nib=0, dev regs=0, hold nibble=0, dev_wr_stb=0, dev_wr_addr=0, sync flops=0.
- Strobe cycle (bus_out[7]=1), at the clock edge:
  - addr_q <= bus_out[6:0].
  - nib <= 0.
  - No writes occur.
- Non-strobe cycle (bus_out[7]=0), at the clock edge:
  - nib toggles (0 = high nibble, 1 = low nibble).
  - Writes below use the pre-edge nib value.
- ram_data is combinational: mem[{bus_out[6], addr_q}], high nibble when nib=0, low nibble when nib=1. It is zero-latency because the CPU samples it in the same cycle.
- RAM write: non-strobe cycle with bus_out[5]=0. Write bus_out[3:0] into the nibble selected by nib, at {bus_out[6], addr_q}. The other nibble is untouched.
- Device write: non-strobe cycle with bus_out[4]=0.
  - nib=0: store bus_out[3:0] in the hold nibble.
  - nib=1: dev_reg[addr_q[2:0]] <= {hold, bus_out[3:0]}; pulse dev_wr_stb for the next cycle with dev_wr_addr=addr_q[2:0].
  - Indices >= N_DEV: the write is ignored and there is no pulse.
- bus_out[5] and bus_out[4] both low in one cycle: both writes are performed.
- dev_data is combinational: synchronised gpio_in[2*addr_q[1:0] +: 2]. Latency from a gpio_in change is SYNC_STAGES cycles.
- prog_we: byte write mem[prog_addr] <= prog_data at the clock edge.
  - On a same-byte collision with a bus RAM write, prog wins and the bus nibble is dropped.
  - Different bytes: both writes are performed.
- A strobe cycle never toggles nib. Back-to-back strobes keep nib=0.
- nib wrap: a third consecutive non-strobe cycle returns nib to 0 (high nibble). No error is raised.
- Reset mid-write: an asserted reset_n clears the hold nibble, so a half-written device byte is lost. RAM nibbles already written stay written.

Decomposition:
- Shared package moonbase_bus_pkg holds the bus bit positions (STROBE=7, SPACE=6, RAM_WN=5, DEV_WN=4, DATA=3:0) and SPACE_CODE=1 / SPACE_DATA=0. The CPU is to be refitted to use the same package.
- One sub-module: moonbase_sync (SYNC_STAGES-deep per-bit synchroniser for gpio_in).
- Memory is an inline 256x8 array with nibble write enables.

Test Plan:
- Preload via prog: code[0x05]=0x7A. Drive strobe with addr 0x05, then two non-strobe cycles with bus_out[6]=1 -> ram_data=0x7 then 0xA.
- Strobe addr 0x10. Non-strobe, space 0, ram_wn=0, data 0x3. Then ram_wn=0, data 0xC -> prog-side check data[0x10]=0x3C; code[0x10] unchanged.
- Strobe addr 0x02. Device writes 0x9 then 0x5 -> dev_out[23:16]=0x95; dev_wr_stb high exactly one cycle with dev_wr_addr=2.
- gpio_in=0b11_10_01_00, strobe addr 0x02, wait SYNC_STAGES cycles -> dev_data=2'b10. Change addr to 0x03 -> dev_data=2'b11.
- Assert reset_n low after the high nibble of a device write, release, then write only the low nibble 0x4 to addr 0x01 -> dev_out[15:8]=0x04. All other dev regs=0.
- Same-cycle prog_we to data[0x20]=0xFF and bus RAM write of the high nibble 0x0 to data 0x20 -> data[0x20]=0xFF.
